// File: rtl/snn_axil_cmd_master.sv
// AXI4-Lite initiator that executes WRITE / READ / POLL commands against the
// SNN core configuration slave and returns one response per command.
module snn_axil_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_GAP           = 4,
    parameter int POLL_TIMEOUT       = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    // command channel
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
    // response channel
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]                      rsp_status,
    output logic                            busy,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // AXI4-Lite write response
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [PW-1:0] TIMEOUT_CNT = PW'(POLL_TIMEOUT);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(POLL_GAP);

    localparam logic [1:0] OP_WRITE     = 2'b00;
    localparam logic [1:0] OP_POLL      = 2'b10;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_POLL_WAIT,
        S_RSP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   mask_q;
    logic [PW-1:0]   poll_cnt;
    logic [PW-1:0]   poll_cnt_inc;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      rd_status;
    logic            poll_match;
    logic            is_poll;
    logic            cmd_fire;

    // Address/data come straight from the latched command registers; they
    // are only rewritten in IDLE, so they stay stable while any VALID is high.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = data_q;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    assign busy         = (state != S_IDLE);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign is_poll      = (op_q == OP_POLL);
    assign poll_match   = (((M_AXI_RDATA ^ data_q) & mask_q) == '0);
    assign poll_cnt_inc = poll_cnt + PW'(1);

    // State register
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the status a finished read/poll reports
    always_comb begin
        state_nxt = state;
        rd_status = M_AXI_RRESP;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (cmd_op == OP_WRITE) ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                // AW and W finish independently; a channel is done once its
                // VALID has dropped or its handshake is happening now.
                if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                    (!M_AXI_WVALID  || M_AXI_WREADY)) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    state_nxt = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if (!is_poll || (M_AXI_RRESP != RESP_OKAY) || poll_match) begin
                        state_nxt = S_RSP;
                    end else if (poll_cnt_inc == TIMEOUT_CNT) begin
                        state_nxt = S_RSP;
                        rd_status = RESP_TIMEOUT;
                    end else begin
                        state_nxt = S_POLL_WAIT;
                    end
                end
            end
            S_POLL_WAIT: begin
                // Loaded with POLL_GAP on entry; a zero gap still spends the
                // single entry cycle here before reissuing the read.
                if (gap_cnt <= GW'(1)) begin
                    state_nxt = S_RD_ADDR;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered AXI handshakes, command latch, counters and response
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            cmd_ready     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_status    <= 2'b00;
            op_q          <= 2'b00;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            cmd_ready <= (state_nxt == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        op_q     <= cmd_op;
                        addr_q   <= cmd_addr;
                        data_q   <= cmd_data;
                        mask_q   <= cmd_mask;
                        poll_cnt <= '0;
                        if (cmd_op == OP_WRITE) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (state_nxt == S_WR_RESP) begin
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_status   <= M_AXI_BRESP;
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (is_poll) begin
                            poll_cnt <= poll_cnt_inc;
                        end
                        if (state_nxt == S_RSP) begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= M_AXI_RDATA;
                            rsp_status <= rd_status;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                S_POLL_WAIT: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                    if (state_nxt == S_RD_ADDR) begin
                        M_AXI_ARVALID <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_axil_cmd_master.sv
// Directed bench for snn_axil_cmd_master with a small reactive AXI-Lite slave.
module tb_snn_axil_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    // slave knobs
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          r_delay  = 0;
    logic [1:0]  bresp_val = 2'b00;
    logic [1:0]  rresp_val = 2'b00;
    logic [31:0] rd_vals [8];
    int          rd_idx = 0;

    // slave/monitor state
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_wait = 0;
    bit aw_got = 0, w_got = 0, r_pending = 0, ar_prev = 0, r_seen = 0;
    int cyc = 0, last_r_cyc = 0;
    int aw_hi = 0, w_hi = 0, b_hs = 0, ar_hs = 0;
    int gap_n = 0, gap_min = 0, gap_max = 0;

    snn_axil_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(16),
        .C_M_AXI_DATA_WIDTH(32),
        .POLL_GAP(4),
        .POLL_TIMEOUT(4)
    ) dut (
        .M_AXI_ACLK(clk),       .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid),  .cmd_ready(cmd_ready),  .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),    .cmd_data(cmd_data),    .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid),  .rsp_ready(rsp_ready),  .rsp_data(rsp_data),
        .rsp_status(rsp_status), .busy(busy),
        .M_AXI_AWADDR(awaddr),  .M_AXI_AWPROT(awprot),  .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),    .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),    .M_AXI_BVALID(bvalid),  .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr),  .M_AXI_ARPROT(arprot),  .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),    .M_AXI_RRESP(rresp),    .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave outputs change on the falling edge, away from the DUT's sampling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0;
        end else begin
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= 0); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            bvalid = aw_got && w_got;
            bresp  = bresp_val;
            if (r_pending) begin
                if (r_wait >= r_delay) begin
                    rvalid = 1;
                    rdata  = rd_vals[rd_idx % 8];
                    rresp  = rresp_val;
                end
                r_wait++;
            end else begin
                rvalid = 0;
                r_wait = 0;
            end
        end
    end

    // Handshake monitor on the rising edge
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            aw_got = 0; w_got = 0; r_pending = 0; ar_prev = 0;
        end else begin
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (awvalid && awready) aw_got = 1;
            if (wvalid && wready) w_got = 1;
            if (bvalid && bready) begin b_hs++; aw_got = 0; w_got = 0; end
            if (arvalid && arready) begin ar_hs++; r_pending = 1; end
            if (arvalid && !ar_prev && r_seen) begin
                if (gap_n == 0) begin
                    gap_min = cyc - last_r_cyc - 1;
                    gap_max = gap_min;
                end else begin
                    if (cyc - last_r_cyc - 1 < gap_min) gap_min = cyc - last_r_cyc - 1;
                    if (cyc - last_r_cyc - 1 > gap_max) gap_max = cyc - last_r_cyc - 1;
                end
                gap_n++;
            end
            if (rvalid && rready) begin
                r_pending = 0; rd_idx++; last_r_cyc = cyc; r_seen = 1;
            end
            ar_prev = arvalid;
        end
    end

    task automatic clear_stats();
        aw_hi = 0; w_hi = 0; b_hs = 0; ar_hs = 0;
        gap_n = 0; r_seen = 0; rd_idx = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] a,
                            input logic [31:0] d, input logic [31:0] m);
        bit ok;
        ok = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        for (int n = 0; n < 50; n++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1 cmd_valid = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready never seen");
        end
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic [1:0] s);
        bit found;
        found = 0; d = 'x; s = 'x;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1; d = rsp_data; s = rsp_status;
                break;
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid never seen");
        end else if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
        rsp_ready = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0)
            begin errors++; $display("FAIL rst_axi_valids: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if ({rsp_data, rsp_status} !== 34'h0) begin errors++; $display("FAIL rst_rsp_regs: got %h/%b want 0/00", rsp_data, rsp_status); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        clear_stats();
        aw_delay = 0; w_delay = 0; bresp_val = 2'b00;
        send_cmd(2'b00, 16'h0004, 32'h0000_0064, 32'h0);
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr_valid_n1: got %b want 11", {awvalid, wvalid}); end
        checks++;
        if (awaddr !== 16'h0004) begin errors++; $display("FAIL wr_awaddr: got %h want 0004", awaddr); end
        checks++;
        if (wdata !== 32'h0000_0064) begin errors++; $display("FAIL wr_wdata: got %h want 00000064", wdata); end
        checks++;
        if (wstrb !== 4'hF) begin errors++; $display("FAIL wr_wstrb: got %h want f", wstrb); end
        @(negedge clk);
        checks++;
        if ({bready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL wr_bready_n2: got %b want 10", {bready, rsp_valid}); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_n3: got %b want 1", rsp_valid); end
        checks++;
        if ({rsp_data, rsp_status} !== 34'h0) begin errors++; $display("FAIL wr_rsp_val: got %h/%b want 0/00", rsp_data, rsp_status); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_aw_delay();
        logic [31:0] d; logic [1:0] s;
        clear_stats();
        aw_delay = 2; w_delay = 0;   // AWREADY arrives in the third AWVALID cycle
        send_cmd(2'b00, 16'h0100, 32'h1234_5678, 32'h0);
        wait_rsp(d, s);
        checks++;
        if (aw_hi !== 3) begin errors++; $display("FAIL awd_aw_cycles: got %0d want 3", aw_hi); end
        checks++;
        if (w_hi !== 1) begin errors++; $display("FAIL awd_w_cycles: got %0d want 1", w_hi); end
        checks++;
        if (b_hs !== 1) begin errors++; $display("FAIL awd_b_hs: got %0d want 1", b_hs); end
        checks++;
        if (s !== 2'b00) begin errors++; $display("FAIL awd_status: got %b want 00", s); end
        aw_delay = 0;
    endtask

    task automatic test_read();
        logic [31:0] d; logic [1:0] s;
        clear_stats();
        r_delay = 2; rresp_val = 2'b00; rd_vals[0] = 32'hDEAD_BEEF;
        send_cmd(2'b01, 16'h0010, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({arvalid, araddr} !== {1'b1, 16'h0010}) begin errors++; $display("FAIL rd_ar: got %b/%h want 1/0010", arvalid, araddr); end
        wait_rsp(d, s);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
        checks++;
        if (s !== 2'b00) begin errors++; $display("FAIL rd_status: got %b want 00", s); end
        r_delay = 0;
    endtask

    task automatic test_poll_match();
        logic [31:0] d; logic [1:0] s;
        clear_stats();
        rd_vals[0] = 32'h1; rd_vals[1] = 32'h1; rd_vals[2] = 32'h0;
        send_cmd(2'b10, 16'h0008, 32'h0, 32'h1);
        wait_rsp(d, s);
        checks++;
        if (ar_hs !== 3) begin errors++; $display("FAIL poll_ar_hs: got %0d want 3", ar_hs); end
        checks++;
        if (gap_n !== 2) begin errors++; $display("FAIL poll_gap_count: got %0d want 2", gap_n); end
        checks++;
        if (gap_min !== 4 || gap_max !== 4) begin errors++; $display("FAIL poll_gap_len: got %0d..%0d want 4", gap_min, gap_max); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL poll_data: got %h want 0", d); end
        checks++;
        if (s !== 2'b00) begin errors++; $display("FAIL poll_status: got %b want 00", s); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] s;
        // poll that never matches: four reads then TIMEOUT with the last value
        clear_stats();
        rd_vals[0] = 32'h11; rd_vals[1] = 32'h12; rd_vals[2] = 32'h13; rd_vals[3] = 32'h14;
        send_cmd(2'b10, 16'h0008, 32'h5A, 32'hFF);
        wait_rsp(d, s);
        checks++;
        if (ar_hs !== 4) begin errors++; $display("FAIL to_ar_hs: got %0d want 4", ar_hs); end
        checks++;
        if (s !== 2'b01) begin errors++; $display("FAIL to_status: got %b want 01", s); end
        checks++;
        if (d !== 32'h14) begin errors++; $display("FAIL to_data: got %h want 00000014", d); end
        // read answered with SLVERR
        clear_stats();
        rresp_val = 2'b10; rd_vals[0] = 32'h0BAD_0BAD;
        send_cmd(2'b01, 16'h0020, 32'h0, 32'h0);
        wait_rsp(d, s);
        checks++;
        if (s !== 2'b10) begin errors++; $display("FAIL slverr_status: got %b want 10", s); end
        checks++;
        if (d !== 32'h0BAD_0BAD) begin errors++; $display("FAIL slverr_data: got %h want 0bad0bad", d); end
        rresp_val = 2'b00;
        // reserved op behaves as READ
        clear_stats();
        rd_vals[0] = 32'h0000_0777;
        send_cmd(2'b11, 16'h0030, 32'h0, 32'h0);
        wait_rsp(d, s);
        checks++;
        if ({ar_hs, d, s} !== {32'd1, 32'h777, 2'b00}) begin errors++; $display("FAIL op11_read: got %0d/%h/%b want 1/777/00", ar_hs, d, s); end
        // write answered with DECERR, data must read back as zero
        clear_stats();
        bresp_val = 2'b11;
        send_cmd(2'b00, 16'h0040, 32'hFFFF_FFFF, 32'h0);
        wait_rsp(d, s);
        checks++;
        if ({d, s} !== {32'h0, 2'b11}) begin errors++; $display("FAIL decerr_rsp: got %h/%b want 0/11", d, s); end
        bresp_val = 2'b00;
    endtask

    task automatic test_backpressure_and_reset();
        logic [31:0] d; logic [1:0] s;
        clear_stats();
        rsp_ready = 0;
        rd_vals[0] = 32'hCAFE_F00D;
        send_cmd(2'b01, 16'h0050, 32'h0, 32'h0);
        wait_rsp(d, s);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_status} !== {1'b1, 1'b0, 32'hCAFE_F00D, 2'b00}) begin
                errors++;
                $display("FAIL hold_rsp: cycle %0d got v=%b rdy=%b %h/%b want 1/0/cafef00d/00", i, rsp_valid, cmd_ready, rsp_data, rsp_status);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got %b want 01", {rsp_valid, cmd_ready}); end
        // reset asserted while stuck in WR
        aw_delay = 10; w_delay = 10;
        send_cmd(2'b00, 16'h0060, 32'h1, 32'h0);
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, busy} !== 3'b111) begin errors++; $display("FAIL mid_wr: got %b want 111", {awvalid, wvalid, busy}); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL async_rst_valids: got %b want 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        checks++;
        if ({busy, cmd_ready} !== 2'b00) begin errors++; $display("FAIL async_rst_state: got %b want 00", {busy, cmd_ready}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        aw_delay = 0; w_delay = 0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, awvalid} !== 3'b100) begin errors++; $display("FAIL after_rst: got %b want 100", {cmd_ready, busy, awvalid}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] s;
        clear_stats();
        send_cmd(2'b00, 16'h0020, 32'hA5A5_0001, 32'h0);
        wait_rsp(d, s);
        checks++;
        if ({d, s} !== 34'h0) begin errors++; $display("FAIL b2b_first: got %h/%b want 0/00", d, s); end
        send_cmd(2'b00, 16'h0024, 32'hA5A5_0002, 32'h0);
        wait_rsp(d, s);
        checks++;
        if ({b_hs, s} !== {32'd2, 2'b00}) begin errors++; $display("FAIL b2b_second: got %0d/%b want 2/00", b_hs, s); end
    endtask

    initial begin
        rd_vals = '{default: 32'h0};
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read();
        test_poll_match();
        test_errors();
        test_backpressure_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
